// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer controller: camera fills one BRAM bank while display reads the other.
// Optional FB_DROP_COUNT_EN adds a saturating count of camera frames dropped while a frame is held.
module fb_pingpong_ctrl #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 19
) (
    input  logic              p_clk,
    input  logic              rst,
    input  logic              cam_frame_start,
    input  logic              cam_frame_done,
    input  logic              cam_pixel_valid,
    input  logic [PIX_W-1:0]  cam_pixel_data,
    input  logic              disp_frame_start,
    input  logic              disp_pixel_req,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_ready,
`ifdef FB_DROP_COUNT_EN
    output logic [7:0]        drop_count,
`endif
    output logic              short_frame
);

    // state  | meaning
    // W_IDLE | write bank free, waiting for camera frame start
    // W_FILL | capturing pixels into wr_bank
    // W_HOLD | complete frame held in wr_bank, waiting for display frame start to swap
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_HOLD = 2'd2
    } wstate_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

    wstate_t             state, state_nxt;
    logic [ADDR_W-1:0]   count, count_nxt;
    logic                wr_en_nxt, wr_bank_nxt, rd_bank_nxt;
    logic                frame_ready_nxt, short_frame_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt, rd_addr_nxt;
    logic [PIX_W-1:0]    wr_data_nxt;

    always_ff @(posedge p_clk) begin
        if (!rst) begin
            state       <= W_IDLE;
            count       <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
            frame_ready <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            wr_en       <= wr_en_nxt;
            wr_bank     <= wr_bank_nxt;
            rd_bank     <= rd_bank_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
            rd_addr     <= rd_addr_nxt;
            frame_ready <= frame_ready_nxt;
            short_frame <= short_frame_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        wr_en_nxt       = 1'b0;
        wr_bank_nxt     = wr_bank;
        rd_bank_nxt     = rd_bank;
        wr_addr_nxt     = wr_addr;
        wr_data_nxt     = wr_data;
        frame_ready_nxt = frame_ready;
        short_frame_nxt = short_frame;

        case (state)
            W_IDLE: begin
                if (cam_frame_start) begin
                    state_nxt   = W_FILL;
                    count_nxt   = '0;
                    wr_addr_nxt = '0;
                end
            end
            W_FILL: begin
                // A fresh frame start resyncs the capture; its cycle carries no pixel.
                if (cam_frame_start) begin
                    count_nxt = '0;
                end else begin
                    if (cam_pixel_valid) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = count;
                        wr_data_nxt = cam_pixel_data;
                        count_nxt   = count + 1'b1;
                        if (count == LAST_PIX) begin
                            state_nxt       = W_HOLD;
                            frame_ready_nxt = 1'b1;
                            short_frame_nxt = 1'b0;
                        end
                    end
                    if (cam_frame_done && !(cam_pixel_valid && count == LAST_PIX)) begin
                        state_nxt       = W_HOLD;
                        frame_ready_nxt = 1'b1;
                        short_frame_nxt = 1'b1;
                    end
                end
            end
            W_HOLD: begin
                if (disp_frame_start) begin
                    state_nxt       = W_IDLE;
                    rd_bank_nxt     = wr_bank;
                    wr_bank_nxt     = ~wr_bank;
                    frame_ready_nxt = 1'b0;
                    short_frame_nxt = 1'b0;
                end
            end
            default: state_nxt = W_IDLE;
        endcase

        rd_addr_nxt = rd_addr;
        if (disp_frame_start)
            rd_addr_nxt = '0;
        else if (disp_pixel_req && rd_addr != LAST_PIX)
            rd_addr_nxt = rd_addr + 1'b1;
    end

`ifdef FB_DROP_COUNT_EN
    // Counts every camera frame start seen while holding, including one that loses to a swap.
    always_ff @(posedge p_clk) begin
        if (!rst)
            drop_count <= '0;
        else if (state == W_HOLD && cam_frame_start && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Scoreboard bench for fb_pingpong_ctrl with a 4x2 frame; drop_count checks follow FB_DROP_COUNT_EN.
module tb_fb_pingpong_ctrl;

    localparam int H_RES  = 4;
    localparam int V_RES  = 2;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 19;

    logic              p_clk = 1'b0;
    logic              rst;
    logic              cam_frame_start, cam_frame_done, cam_pixel_valid;
    logic [PIX_W-1:0]  cam_pixel_data;
    logic              disp_frame_start, disp_pixel_req;
    logic              wr_en, wr_bank, rd_bank, frame_ready, short_frame;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [PIX_W-1:0]  wr_data;
`ifdef FB_DROP_COUNT_EN
    logic [7:0]        drop_count;
`endif

    typedef struct {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
        int                cyc;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc   = 0;

    fb_pingpong_ctrl #(
        .H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
    ) dut (
        .p_clk(p_clk),
        .rst(rst),
        .cam_frame_start(cam_frame_start),
        .cam_frame_done(cam_frame_done),
        .cam_pixel_valid(cam_pixel_valid),
        .cam_pixel_data(cam_pixel_data),
        .disp_frame_start(disp_frame_start),
        .disp_pixel_req(disp_pixel_req),
        .wr_en(wr_en),
        .wr_bank(wr_bank),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .frame_ready(frame_ready),
`ifdef FB_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .short_frame(short_frame)
    );

    always #5 p_clk = ~p_clk;
    always @(posedge p_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic push_wr(input logic bank, input int addr, input int data);
        wr_exp_t e;
        e.bank = bank;
        e.addr = ADDR_W'(addr);
        e.data = PIX_W'(data);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic pixel(input logic bank, input int addr, input int data);
        cam_pixel_valid = 1'b1;
        cam_pixel_data  = PIX_W'(data);
        push_wr(bank, addr, data);
        tick();
        cam_pixel_valid = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected write, on its expected cycle.
    always @(negedge p_clk) begin
        wr_exp_t e;
        if (rst === 1'b1) check("bank_invariant", 32'(rd_bank != wr_bank), 32'd1);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_bank", 32'(wr_bank), 32'(e.bank));
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        cam_frame_start = 0; cam_frame_done = 0; cam_pixel_valid = 0;
        cam_pixel_data = '0; disp_frame_start = 0; disp_pixel_req = 0;
        tick(); tick();
        check("rst_wr_bank", 32'(wr_bank), 0);
        check("rst_rd_bank", 32'(rd_bank), 1);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_frame_ready", 32'(frame_ready), 0);
        rst = 1'b1;
        tick();

        // Full frame into bank 0
        cam_frame_start = 1; tick(); cam_frame_start = 0;
        for (int i = 0; i < 8; i++) pixel(1'b0, i, i + 1);
        check("full_frame_ready", 32'(frame_ready), 1);
        check("full_short", 32'(short_frame), 0);
        tick();

        // Swap, then read past the end
        disp_frame_start = 1; tick(); disp_frame_start = 0;
        check("swap1_rd_bank", 32'(rd_bank), 0);
        check("swap1_wr_bank", 32'(wr_bank), 1);
        check("swap1_frame_ready", 32'(frame_ready), 0);
        check("swap1_rd_addr", 32'(rd_addr), 0);
        disp_pixel_req = 1;
        repeat (10) tick();
        disp_pixel_req = 0;
        check("rd_saturate", 32'(rd_addr), 7);

        // Display restart without a held frame
        disp_frame_start = 1; tick(); disp_frame_start = 0;
        check("noswap_rd_addr", 32'(rd_addr), 0);
        check("noswap_rd_bank", 32'(rd_bank), 0);
        check("noswap_wr_bank", 32'(wr_bank), 1);

        // Short frame into bank 1
        cam_frame_start = 1; tick(); cam_frame_start = 0;
        for (int i = 0; i < 3; i++) pixel(1'b1, i, 12'h0A0 + i);
        cam_frame_done = 1; tick(); cam_frame_done = 0;
        check("short_flag", 32'(short_frame), 1);
        check("short_frame_ready", 32'(frame_ready), 1);

        // Dropped frames while holding
        for (int i = 0; i < 100; i++) begin
            cam_frame_start = 1; cam_pixel_valid = 1; cam_pixel_data = 12'hBAD;
            tick();
            cam_frame_start = 0; cam_frame_done = 1;
            tick();
            cam_frame_done = 0; cam_pixel_valid = 0;
        end
`ifdef FB_DROP_COUNT_EN
        check("drop_100", 32'(drop_count), 100);
`endif
        for (int i = 0; i < 200; i++) begin
            cam_frame_start = 1; tick(); cam_frame_start = 0; tick();
        end
        check("hold_frame_ready", 32'(frame_ready), 1);
        check("hold_wr_en", 32'(wr_en), 0);
`ifdef FB_DROP_COUNT_EN
        check("drop_sat", 32'(drop_count), 255);
`endif
        disp_frame_start = 1; tick(); disp_frame_start = 0;
        check("swap2_rd_bank", 32'(rd_bank), 1);
        check("swap2_wr_bank", 32'(wr_bank), 0);
`ifdef FB_DROP_COUNT_EN
        check("drop_kept", 32'(drop_count), 255);
`endif

        // Reset in the middle of a fill
        cam_frame_start = 1; tick(); cam_frame_start = 0;
        pixel(1'b0, 0, 12'h111);
        pixel(1'b0, 1, 12'h222);
        disp_pixel_req = 1; tick(); disp_pixel_req = 0;
        rst = 0; cam_pixel_valid = 1; cam_pixel_data = 12'h333;
        tick();
        cam_pixel_valid = 0;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_wr_addr", 32'(wr_addr), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_rd_addr", 32'(rd_addr), 0);
        check("mid_rst_wr_bank", 32'(wr_bank), 0);
        check("mid_rst_rd_bank", 32'(rd_bank), 1);
        check("mid_rst_short", 32'(short_frame), 0);
        check("mid_rst_frame_ready", 32'(frame_ready), 0);
`ifdef FB_DROP_COUNT_EN
        check("mid_rst_drop", 32'(drop_count), 0);
`endif
        rst = 1; tick();

        // Display start coincides with the final write
        cam_frame_start = 1; tick(); cam_frame_start = 0;
        disp_pixel_req = 1;
        for (int i = 0; i < 7; i++) pixel(1'b0, i, 12'h700 + i);
        check("pre_coinc_rd_addr", 32'(rd_addr), 7);
        disp_frame_start = 1;
        pixel(1'b0, 7, 12'h7FF);
        disp_frame_start = 0; disp_pixel_req = 0;
        check("coinc_frame_ready", 32'(frame_ready), 1);
        check("coinc_rd_bank", 32'(rd_bank), 1);
        check("coinc_wr_bank", 32'(wr_bank), 0);
        check("coinc_rd_addr", 32'(rd_addr), 0);
        tick();
        check("coinc_still_held", 32'(frame_ready), 1);
        disp_frame_start = 1; tick(); disp_frame_start = 0;
        check("swap3_rd_bank", 32'(rd_bank), 0);
        check("swap3_wr_bank", 32'(wr_bank), 1);
        check("swap3_frame_ready", 32'(frame_ready), 0);

        tick(); tick();
        check("writes_outstanding", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
